// File: rtl/data_memory.sv
// Word-organised data memory for the single-cycle MIPS32 core's lw/sw path.
// Synchronous full-word writes, combinational gated reads, asynchronous clear.
module data_memory #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned IDX_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              WriteEn,
    input  logic              ReadEn,
    output logic [DATA_W-1:0] ReadData
);

    localparam logic [31:0] DepthLim = 32'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  wordIdx;
    logic              inRange;

    // The full 32-bit addr is compared, so any upper bit set rejects the access.
    assign wordIdx = addr[IDX_W-1:0];
    assign inRange = (addr < DepthLim);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '{default: '0};
        end else if (WriteEn && inRange) begin
            mem[wordIdx] <= WriteData;
        end
    end

    always_comb begin
        ReadData = '0;
        if (rst_n && ReadEn && inRange) begin
            ReadData = mem[wordIdx];
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: expected words are queued when stimulus
// is driven and popped when the combinational read result is sampled.
module tb_data_memory;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned IDX_W  = 8;

    logic              clk;
    logic              rst_n;
    logic [31:0]       addr;
    logic [DATA_W-1:0] WriteData;
    logic              WriteEn;
    logic              ReadEn;
    logic [DATA_W-1:0] ReadData;

    int unsigned numCompared;
    int unsigned numMismatched;
    logic [DATA_W-1:0] expQ [$];
    logic [DATA_W-1:0] got;
    logic [DATA_W-1:0] expv;

    data_memory #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .WriteData(WriteData),
        .WriteEn  (WriteEn),
        .ReadEn   (ReadEn),
        .ReadData (ReadData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle write pulse, driven away from the rising edge.
    task automatic do_write(input logic [31:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        addr      = a;
        WriteData = d;
        WriteEn   = 1'b1;
        ReadEn    = 1'b0;
        @(negedge clk);
        WriteEn   = 1'b0;
    endtask

    task automatic observe(input logic [31:0] a, input logic en, output logic [DATA_W-1:0] obs);
        @(negedge clk);
        addr    = a;
        ReadEn  = en;
        WriteEn = 1'b0;
        #1;
        obs = ReadData;
    endtask

    task automatic test_reset;
        do_write(32'd4, 32'h0000_00AA);
        do_write(32'd5, 32'h0000_00BB);
        @(negedge clk);
        addr   = 32'd4;
        ReadEn = 1'b1;
        #2;
        rst_n = 1'b0;
        expQ.push_back(32'h0);
        #1;
        got  = ReadData;
        expv = expQ.pop_front();
        numCompared++;
        if (got !== expv) begin
            $display("FAIL reset_read_during: got %h expected %h", got, expv);
            numMismatched++;
        end
        // Writes must be blocked while reset is held.
        WriteData = 32'hCAFE_F00D;
        WriteEn   = 1'b1;
        @(posedge clk);
        #1;
        WriteEn = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        expQ.push_back(32'h0);
        expQ.push_back(32'h0);
        observe(32'd4, 1'b1, got);
        expv = expQ.pop_front();
        numCompared++;
        if (got !== expv) begin
            $display("FAIL reset_addr4_after: got %h expected %h", got, expv);
            numMismatched++;
        end
        observe(32'd5, 1'b1, got);
        expv = expQ.pop_front();
        numCompared++;
        if (got !== expv) begin
            $display("FAIL reset_addr5_after: got %h expected %h", got, expv);
            numMismatched++;
        end
        // First write on the first rising edge after release.
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n     = 1'b1;
        addr      = 32'd9;
        WriteData = 32'h0000_1234;
        WriteEn   = 1'b1;
        expQ.push_back(32'h0000_1234);
        @(negedge clk);
        WriteEn = 1'b0;
        observe(32'd9, 1'b1, got);
        expv = expQ.pop_front();
        numCompared++;
        if (got !== expv) begin
            $display("FAIL reset_first_write: got %h expected %h", got, expv);
            numMismatched++;
        end
    endtask

    task automatic test_write_read;
        do_write(32'd4, 32'd32);
        expQ.push_back(32'h0000_0020);
        observe(32'd4, 1'b1, got);
        expv = expQ.pop_front();
        numCompared++;
        if (got !== expv) begin
            $display("FAIL write_read_addr4: got %h expected %h", got, expv);
            numMismatched++;
        end
    endtask

    task automatic test_negative;
        do_write(32'd5, -32'sd65);
        expQ.push_back(32'hFFFF_FFBF);
        expQ.push_back(32'h0000_0020);
        observe(32'd5, 1'b1, got);
        expv = expQ.pop_front();
        numCompared++;
        if (got !== expv) begin
            $display("FAIL negative_addr5: got %h expected %h", got, expv);
            numMismatched++;
        end
        observe(32'd4, 1'b1, got);
        expv = expQ.pop_front();
        numCompared++;
        if (got !== expv) begin
            $display("FAIL adjacent_addr4: got %h expected %h", got, expv);
            numMismatched++;
        end
    endtask

    task automatic test_enables;
        expQ.push_back(32'h0);
        observe(32'd4, 1'b0, got);
        expv = expQ.pop_front();
        numCompared++;
        if (got !== expv) begin
            $display("FAIL readen_low: got %h expected %h", got, expv);
            numMismatched++;
        end
        @(negedge clk);
        addr      = 32'd4;
        WriteData = 32'h5555_AAAA;
        WriteEn   = 1'b0;
        @(negedge clk);
        expQ.push_back(32'h0000_0020);
        observe(32'd4, 1'b1, got);
        expv = expQ.pop_front();
        numCompared++;
        if (got !== expv) begin
            $display("FAIL writeen_low: got %h expected %h", got, expv);
            numMismatched++;
        end
    endtask

    task automatic test_out_of_range;
        do_write(32'd0, 32'h1234_5678);
        do_write(32'd256, 32'hDEAD_BEEF);
        do_write(32'h8000_0001, 32'hBAAD_F00D);
        expQ.push_back(32'h0);
        expQ.push_back(32'h1234_5678);
        expQ.push_back(32'h0);
        expQ.push_back(32'h0);
        observe(32'd256, 1'b1, got);
        expv = expQ.pop_front();
        numCompared++;
        if (got !== expv) begin
            $display("FAIL oor_read_256: got %h expected %h", got, expv);
            numMismatched++;
        end
        observe(32'd0, 1'b1, got);
        expv = expQ.pop_front();
        numCompared++;
        if (got !== expv) begin
            $display("FAIL oor_no_wrap_addr0: got %h expected %h", got, expv);
            numMismatched++;
        end
        observe(32'd1, 1'b1, got);
        expv = expQ.pop_front();
        numCompared++;
        if (got !== expv) begin
            $display("FAIL oor_upper_bit_addr1: got %h expected %h", got, expv);
            numMismatched++;
        end
        observe(32'h8000_0004, 1'b1, got);
        expv = expQ.pop_front();
        numCompared++;
        if (got !== expv) begin
            $display("FAIL oor_read_upper: got %h expected %h", got, expv);
            numMismatched++;
        end
    endtask

    task automatic test_same_cycle;
        do_write(32'd7, 32'h1);
        @(negedge clk);
        addr      = 32'd7;
        WriteData = 32'h2;
        WriteEn   = 1'b1;
        ReadEn    = 1'b1;
        expQ.push_back(32'h1);
        expQ.push_back(32'h2);
        #1;
        got  = ReadData;
        expv = expQ.pop_front();
        numCompared++;
        if (got !== expv) begin
            $display("FAIL same_cycle_before: got %h expected %h", got, expv);
            numMismatched++;
        end
        @(posedge clk);
        #1;
        got  = ReadData;
        expv = expQ.pop_front();
        numCompared++;
        if (got !== expv) begin
            $display("FAIL same_cycle_after: got %h expected %h", got, expv);
            numMismatched++;
        end
        @(negedge clk);
        WriteEn = 1'b0;
    endtask

    task automatic test_boundary;
        do_write(32'd255, 32'hA5A5_5A5A);
        expQ.push_back(32'hA5A5_5A5A);
        expQ.push_back(32'h1234_5678);
        observe(32'd255, 1'b1, got);
        expv = expQ.pop_front();
        numCompared++;
        if (got !== expv) begin
            $display("FAIL boundary_255: got %h expected %h", got, expv);
            numMismatched++;
        end
        observe(32'd0, 1'b1, got);
        expv = expQ.pop_front();
        numCompared++;
        if (got !== expv) begin
            $display("FAIL boundary_addr0: got %h expected %h", got, expv);
            numMismatched++;
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) begin
            do_write(32'(16 + i), 32'(32'h0100_0000 * (i + 1) + i));
            expQ.push_back(32'(32'h0100_0000 * (i + 1) + i));
        end
        for (int i = 0; i < 8; i++) begin
            observe(32'(16 + i), 1'b1, got);
            expv = expQ.pop_front();
            numCompared++;
            if (got !== expv) begin
                $display("FAIL back_to_back[%0d]: got %h expected %h", i, got, expv);
                numMismatched++;
            end
        end
    endtask

    initial begin
        numCompared   = 0;
        numMismatched = 0;
        rst_n     = 1'b0;
        addr      = '0;
        WriteData = '0;
        WriteEn   = 1'b0;
        ReadEn    = 1'b0;
        #1;
        ReadEn = 1'b1;
        #1;
        got = ReadData;
        numCompared++;
        if (got !== 32'h0) begin
            $display("FAIL initial_reset: got %h expected %h", got, 32'h0);
            numMismatched++;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        test_write_read();
        test_negative();
        test_enables();
        test_out_of_range();
        test_same_cycle();
        test_boundary();
        test_back_to_back();
        test_reset();

        if (expQ.size() != 0) begin
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", expQ.size());
            numMismatched++;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
